// File: rtl/bd_input_arbiter.sv
// bd_input_arbiter
//   Round-robin arbiter that funnels Nin requester streams into one registered
//   output toward the BD. A grant lasts up to eff_burst words (burst_len latched
//   at grant time, 0 treated as 1). The grant also ends early when the granted
//   requester drops valid or its enable. Every grant is preceded by a
//   one-cycle arbitration bubble in IDLE.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   in_d       per-requester data word       [Nin][NBDdata]
//   in_v       per-requester valid
//   in_a       per-requester accept (only the granted, enabled requester)
//   enable     per-requester enable mask
//   burst_len  max words per grant (0 -> 1)
//   out_d      registered output word
//   out_v      output valid
//   out_a      downstream accept
//   grant_idx  current / last granted requester
//   busy       high while a grant is active
module bd_input_arbiter #(
  parameter int NBDdata = 21,
  parameter int Nin     = 4,
  parameter int Nburst  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [Nin-1:0][NBDdata-1:0]     in_d,
  input  logic [Nin-1:0]                  in_v,
  output logic [Nin-1:0]                  in_a,
  input  logic [Nin-1:0]                  enable,
  input  logic [Nburst-1:0]               burst_len,
  output logic [NBDdata-1:0]              out_d,
  output logic                            out_v,
  input  logic                            out_a,
  output logic [$clog2(Nin)-1:0]          grant_idx,
  output logic                            busy
);

  localparam int              IW       = $clog2(Nin);
  localparam logic [IW:0]     NIN_W    = (IW+1)'(Nin);
  localparam logic [IW-1:0]   LAST_IDX = IW'(Nin - 1);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [Nburst-1:0]    cnt_q, cnt_d;
  logic [Nburst-1:0]    eff_q, eff_d;
  logic [NBDdata-1:0]   od_q, od_d;
  logic                 ov_q, ov_d;

  logic [Nin-1:0]       req;
  logic [IW:0]          idx;
  logic [IW-1:0]        sel;
  logic                 found;
  logic                 g_v, g_en, g_acc, xfer, last;
  logic [Nburst:0]      cnt_inc;

  // First requesting index at or after ptr, wrapping at Nin. idx is one bit
  // wider than an index so ptr+k (max 2*Nin-2) never overflows before the
  // modulo fold, which keeps non-power-of-two Nin correct.
  always_comb begin
    req   = in_v & enable;
    idx   = '0;
    sel   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < Nin; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= NIN_W) idx = idx - NIN_W;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  // Accept toward the granted requester depends only on its enable and on
  // output-register space, so a drain and a load can share one cycle.
  always_comb begin
    g_v     = in_v[gidx_q];
    g_en    = enable[gidx_q];
    g_acc   = (state_q == S_GRANTED) && g_en && (!ov_q || out_a);
    xfer    = g_acc && g_v;
    cnt_inc = {1'b0, cnt_q} + (Nburst+1)'(1);
    last    = xfer && (cnt_inc == {1'b0, eff_q});
    in_a    = '0;
    if (state_q == S_GRANTED) in_a[gidx_q] = g_acc;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    eff_d   = eff_q;
    od_d    = od_q;
    ov_d    = ov_q && !out_a;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gidx_d  = sel;
          cnt_d   = '0;
          eff_d   = (burst_len == '0) ? Nburst'(1) : burst_len;
          state_d = S_GRANTED;
        end
      end
      S_GRANTED: begin
        if (xfer) begin
          od_d  = in_d[gidx_q];
          ov_d  = 1'b1;
          cnt_d = cnt_inc[Nburst-1:0];
        end
        if (last || !g_v || !g_en) begin
          state_d = S_IDLE;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      eff_q   <= Nburst'(1);
      od_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
    end
  end

  assign out_d     = od_q;
  assign out_v     = ov_q;
  assign grant_idx = gidx_q;
  assign busy      = (state_q == S_GRANTED);

endmodule
